wb_bus_v2: RTL and testbench
============================

WB_BUS_V2 -- requirements
Module: wb_bus_v2

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width. DW, default 32, data width, multiple of 8. SW = DW/8, derived, select width. TIMEOUT, default 16, max wait cycles for a response (0 = disabled). MAX_RETRY, default 2, retries allowed on rty.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  stall_i  in  6  pipeline stall vector from CTRL
  flush_i  in  1  pipeline flush
  cpu_ce_i  in  1  CPU access request
  cpu_addr_i  in  AW  CPU address
  cpu_data_i  in  DW  CPU write data
  cpu_we_i  in  1  write enable
  cpu_sel_i  in  SW  byte select
  cpu_data_o  out  DW  read data to CPU
  stallreq  out  1  stall request to CTRL
  bus_err_o  out  1  access terminated by error/timeout/retry exhaustion
  wishbone_addr_o  out  AW  bus address
  wishbone_data_o  out  DW  bus write data
  wishbone_we_o  out  1  bus write enable
  wishbone_sel_o  out  SW  bus byte select
  wishbone_stb_o  out  1  strobe
  wishbone_cyc_o  out  1  cycle
  wishbone_data_i  in  DW  slave read data
  wishbone_ack_i  in  1  normal termination
  wishbone_err_i  in  1  error termination
  wishbone_rty_i  in  1  retry termination

Function
REQ-003 FSM states SHALL be IDLE, BUSY, RETRY_GAP, WAIT_FOR_STALL, each with a distinct encoding.
REQ-004 IDLE: when cpu_ce_i=1 and flush_i=0, on the next edge latch addr/data/we/sel onto the bus, set stb=cyc=1, clear the retry and timeout counters, clear read buffer and error flag, and enter BUSY.
REQ-005 stallreq SHALL be combinational: 1 in IDLE while a request is pending (cpu_ce_i=1, flush_i=0); 1 in BUSY and RETRY_GAP unless a terminal event occurs this cycle; 0 otherwise.
REQ-006 BUSY event priority SHALL be ack > err > rty > timeout > flush.
REQ-007 Ack: same cycle, cpu_data_o=wishbone_data_i if wishbone_we_o=0, else 0; stallreq=0; bus_err_o=0. Next edge: drop all bus outputs to zero and buffer read data; enter WAIT_FOR_STALL if stall_i!=0, else IDLE.
REQ-008 Err: same cycle, stallreq=0, cpu_data_o=0, bus_err_o=1. Next edge: drop bus outputs, set the error flag, and zero the buffer. Next state follows the REQ-007 rule.
REQ-009 Rty with retry_cnt<MAX_RETRY: next edge drops stb/cyc (addr/data/we/sel held), increments retry_cnt, and enters RETRY_GAP. Rty with retry_cnt=MAX_RETRY is handled as err.
REQ-010 RETRY_GAP lasts exactly one cycle: on flush_i=1 clear the bus and go to IDLE; otherwise reassert stb=cyc=1, clear the timeout counter, and return to BUSY.
REQ-011 Timeout: the counter increments each BUSY cycle without ack/err/rty. When the counter equals TIMEOUT-1 and no response is present, the access is handled as err. TIMEOUT=0 disables this.
REQ-012 Flush in BUSY with no response: next edge clears the bus outputs, buffer and error flag, and enters IDLE; bus_err_o=0.
REQ-013 WAIT_FOR_STALL: stallreq=0, cpu_data_o=buffer, bus_err_o=error flag; go to IDLE when stall_i=0.
REQ-014 Bus outputs SHALL remain constant for the whole of BUSY.
REQ-015 Counter widths SHALL be sized for their maximum value with no wrap. Read data SHALL be passed through at full DW with no extension.

Reset
REQ-016 While rst=1, asynchronously: state=IDLE; all wishbone_*_o=0; buffer, counters and error flag =0; stallreq=0, cpu_data_o=0, bus_err_o=0.
REQ-017 Reset asserted mid-access SHALL drop stb/cyc immediately. After release the FSM SHALL start from IDLE.

Verification
REQ-018 Read, ack after 3 cycles, stall_i=0: addr 0x100 → stb/cyc high 3 cycles; cpu_data_o=0xDEADBEEF in the ack cycle; stallreq falls the same cycle; state IDLE next.
REQ-019 Read, ack while stall_i=6'b000011: cpu_data_o holds 0xDEADBEEF in WAIT_FOR_STALL; return to IDLE on the first cycle with stall_i=0.
REQ-020 MAX_RETRY=2, rty on 3 consecutive attempts: exactly two one-cycle stb gaps occur; the third rty gives bus_err_o=1, cpu_data_o=0, stallreq=0.
REQ-021 TIMEOUT=16, no response: bus_err_o=1 in the 16th BUSY cycle; stb drops the next cycle.
REQ-022 Write, flush_i in the 2nd BUSY cycle: bus cleared next edge; bus_err_o stays 0; IDLE. A subsequent request is accepted normally.
REQ-023 rst asserted in BUSY: stb/cyc=0 without waiting for a clock edge. After release, one read completes normally.

Source files
------------

// File: rtl/wb_bus_v2.sv
// wb_bus_v2: CPU-to-Wishbone bridge with retry, timeout, flush and stall handshaking
module wb_bus_v2 #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2,
    localparam int SW       = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall_i,
    input  logic          flush_i,
    input  logic          cpu_ce_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    input  logic          cpu_we_i,
    input  logic [SW-1:0] cpu_sel_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          stallreq,
    output logic          bus_err_o,
    output logic [AW-1:0] wishbone_addr_o,
    output logic [DW-1:0] wishbone_data_o,
    output logic          wishbone_we_o,
    output logic [SW-1:0] wishbone_sel_o,
    output logic          wishbone_stb_o,
    output logic          wishbone_cyc_o,
    input  logic [DW-1:0] wishbone_data_i,
    input  logic          wishbone_ack_i,
    input  logic          wishbone_err_i,
    input  logic          wishbone_rty_i
);
    typedef enum logic [1:0] {IDLE, BUSY, RETRY_GAP, WAIT_FOR_STALL} state_t;

    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdat_q, wdat_d, rbuf_q, rbuf_d;
    logic          we_q, we_d, stb_q, stb_d, err_q, err_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [RW-1:0] rty_q, rty_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy, req, tmo_hit, ev_ack, ev_err, ev_rty, ev_flush, clr;

    assign busy     = state_q == BUSY;
    assign req      = cpu_ce_i & ~flush_i;
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign ev_ack   = busy & wishbone_ack_i;
    assign ev_err   = busy & ~wishbone_ack_i & (wishbone_err_i | (wishbone_rty_i & (rty_q == RTY_MAX)) | (~wishbone_rty_i & tmo_hit));
    assign ev_rty   = busy & ~wishbone_ack_i & ~wishbone_err_i & wishbone_rty_i & (rty_q != RTY_MAX);
    assign ev_flush = busy & ~wishbone_ack_i & ~wishbone_err_i & ~wishbone_rty_i & ~tmo_hit & flush_i;

    assign stallreq   = ~rst & (state_q == IDLE ? req : busy ? ~(ev_ack | ev_err | ev_flush) : state_q == RETRY_GAP ? ~flush_i : 1'b0);
    assign cpu_data_o = ev_ack ? (we_q ? '0 : wishbone_data_i) : state_q == WAIT_FOR_STALL ? rbuf_q : '0;
    assign bus_err_o  = ev_err | (state_q == WAIT_FOR_STALL & err_q);

    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = wdat_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_cyc_o  = stb_q;

    // next-state, latched bus request, counters and response buffer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        rbuf_d  = rbuf_q;
        err_d   = err_q;
        rty_d   = rty_q;
        tmo_d   = tmo_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                addr_d  = cpu_addr_i;
                wdat_d  = cpu_data_i;
                we_d    = cpu_we_i;
                sel_d   = cpu_sel_i;
                stb_d   = 1'b1;
                rty_d   = '0;
                tmo_d   = '0;
                rbuf_d  = '0;
                err_d   = 1'b0;
            end
            BUSY: if (ev_ack | ev_err) begin
                clr     = 1'b1;
                rbuf_d  = (ev_ack & ~we_q) ? wishbone_data_i : '0;
                err_d   = ev_err;
                state_d = |stall_i ? WAIT_FOR_STALL : IDLE;
            end else if (ev_rty) begin
                stb_d   = 1'b0;
                rty_d   = rty_q + 1'b1;
                state_d = RETRY_GAP;
            end else if (ev_flush) begin
                clr     = 1'b1;
                rbuf_d  = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end else if (TIMEOUT != 0) begin
                tmo_d = tmo_q + 1'b1;
            end
            RETRY_GAP: if (flush_i) begin
                clr     = 1'b1;
                state_d = IDLE;
            end else begin
                stb_d   = 1'b1;
                tmo_d   = '0;
                state_d = BUSY;
            end
            WAIT_FOR_STALL: if (~|stall_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            addr_d = '0;
            wdat_d = '0;
            we_d   = 1'b0;
            sel_d  = '0;
            stb_d  = 1'b0;
        end
    end

    // state and datapath registers, cleared asynchronously so stb/cyc drop at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            stb_q   <= 1'b0;
            rbuf_q  <= '0;
            err_q   <= 1'b0;
            rty_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            rbuf_q  <= rbuf_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_wb_bus_v2.sv
// tb_wb_bus_v2: directed stimulus with an access-level reference model checked every cycle
module tb_wb_bus_v2;
    localparam int AW = 32, DW = 32, SW = 4, TIMEOUT = 16, MAX_RETRY = 2;

    logic          clk = 1'b0, rst = 1'b1;
    logic [5:0]    stall = '0;
    logic          flush = 1'b0, ce = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdat = '0, rdat = '0;
    logic [SW-1:0] sel = '0;
    logic          ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [DW-1:0] cpu_data_o, wb_data_o;
    logic          stallreq, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [AW-1:0] wb_addr_o;
    logic [SW-1:0] wb_sel_o;

    int checks = 0, failures = 0;

    wb_bus_v2 #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .cpu_ce_i(ce),
        .cpu_addr_i(addr), .cpu_data_i(wdat), .cpu_we_i(we), .cpu_sel_i(sel),
        .cpu_data_o(cpu_data_o), .stallreq(stallreq), .bus_err_o(bus_err_o),
        .wishbone_addr_o(wb_addr_o), .wishbone_data_o(wb_data_o), .wishbone_we_o(wb_we_o),
        .wishbone_sel_o(wb_sel_o), .wishbone_stb_o(wb_stb_o), .wishbone_cyc_o(wb_cyc_o),
        .wishbone_data_i(rdat), .wishbone_ack_i(ack), .wishbone_err_i(err), .wishbone_rty_i(rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: an access is "on" from acceptance until it ends; "gap" marks the idle strobe between attempts
    bit            m_on = 0, m_gap = 0, m_wait = 0, m_we = 0, m_err = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_buf = '0;
    logic [SW-1:0] m_sel = '0;
    int            m_n = 0, m_rty = 0, r;
    bit            e_stb, e_stall, e_err;
    logic [DW-1:0] e_cpu;

    always @(negedge clk) begin
        if (rst) begin
            m_on = 0; m_gap = 0; m_wait = 0; m_err = 0; m_buf = '0; m_n = 0; m_rty = 0;
            r = 0; e_stb = 0; e_stall = 0; e_err = 0; e_cpu = '0;
        end else begin
            e_stb = m_on && !m_gap;
            if (!e_stb) r = 0;
            else if (ack) r = 1;
            else if (err) r = 2;
            else if (rty) r = (m_rty == MAX_RETRY) ? 2 : 3;
            else if (TIMEOUT != 0 && m_n == TIMEOUT) r = 2;
            else if (flush) r = 4;
            else r = 0;
            e_stall = m_wait ? 0 : e_stb ? (r == 0 || r == 3) : m_gap ? !flush : (ce && !flush);
            e_cpu   = (r == 1) ? (m_we ? '0 : rdat) : m_wait ? m_buf : '0;
            e_err   = (r == 2) ? 1 : m_wait ? m_err : 0;
        end
        chk("stb", wb_stb_o, e_stb);
        chk("cyc", wb_cyc_o, e_stb);
        chk("addr", wb_addr_o, m_on ? m_addr : '0);
        chk("wdata", wb_data_o, m_on ? m_data : '0);
        chk("we", wb_we_o, m_on ? m_we : 1'b0);
        chk("sel", wb_sel_o, m_on ? m_sel : '0);
        chk("stallreq", stallreq, e_stall);
        chk("cpu_data", cpu_data_o, e_cpu);
        chk("bus_err", bus_err_o, e_err);
        if (!rst) begin
            if (m_wait) begin
                if (stall == 0) m_wait = 0;
            end else if (m_gap) begin
                m_gap = 0;
                if (flush) m_on = 0;
                else m_n = 1;
            end else if (m_on) begin
                case (r)
                    1: begin m_on = 0; m_buf = m_we ? '0 : rdat; m_err = 0; m_wait = stall != 0; end
                    2: begin m_on = 0; m_buf = '0; m_err = 1; m_wait = stall != 0; end
                    3: begin m_gap = 1; m_rty++; end
                    4: begin m_on = 0; m_buf = '0; m_err = 0; end
                    default: m_n++;
                endcase
            end else if (ce && !flush) begin
                m_on = 1; m_addr = addr; m_data = wdat; m_we = we; m_sel = sel;
                m_n = 1; m_rty = 0; m_buf = '0; m_err = 0;
            end
        end
    end

    initial begin
        ce = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // read at 0x100, ack in the third busy cycle
        ce = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'hF;
        tick(); ce = 1'b0; #3 chk("t1 stb c1", wb_stb_o, 1'b1);
        tick(); #3 chk("t1 stb c2", wb_stb_o, 1'b1);
        tick(); ack = 1'b1; rdat = 32'hDEADBEEF;
        #3 chk("t1 ack data", cpu_data_o, 32'hDEADBEEF); chk("t1 ack stallreq", stallreq, 1'b0);
        // next read is accepted straight away, showing the bridge is idle; ack under stall
        tick(); ack = 1'b0; rdat = '0; ce = 1'b1; addr = 32'h200;
        #3 chk("t1 idle stb", wb_stb_o, 1'b0); chk("t2 idle stallreq", stallreq, 1'b1);
        tick(); ce = 1'b0;
        tick(); ack = 1'b1; rdat = 32'hDEADBEEF; stall = 6'b000011;
        tick(); ack = 1'b0; rdat = '0;
        #3 chk("t2 wait data", cpu_data_o, 32'hDEADBEEF); chk("t2 wait stallreq", stallreq, 1'b0);
        tick(); #3 chk("t2 wait data 2", cpu_data_o, 32'hDEADBEEF);
        tick(); stall = '0; #3 chk("t2 wait data 3", cpu_data_o, 32'hDEADBEEF);
        tick(); #3 chk("t2 idle data", cpu_data_o, 32'h0);
        // three retries: two one-cycle gaps then an error
        ce = 1'b1; addr = 32'h300;
        tick(); ce = 1'b0; rty = 1'b1; #3 chk("t3 rty1 stallreq", stallreq, 1'b1);
        tick(); rty = 1'b0; #3 chk("t3 gap1 stb", wb_stb_o, 1'b0); chk("t3 gap1 addr", wb_addr_o, 32'h300);
        tick(); rty = 1'b1; #3 chk("t3 busy2 stb", wb_stb_o, 1'b1);
        tick(); rty = 1'b0; #3 chk("t3 gap2 stb", wb_stb_o, 1'b0);
        tick(); rty = 1'b1;
        #3 chk("t3 final err", bus_err_o, 1'b1); chk("t3 final data", cpu_data_o, 32'h0); chk("t3 final stallreq", stallreq, 1'b0);
        tick(); rty = 1'b0; #3 chk("t3 after stb", wb_stb_o, 1'b0); chk("t3 after err", bus_err_o, 1'b0);
        // no response: timeout in the 16th busy cycle
        ce = 1'b1; addr = 32'h400;
        for (int i = 1; i <= 16; i++) begin
            tick(); ce = 1'b0;
            #3 chk("t4 timeout err", bus_err_o, i == 16); chk("t4 busy stb", wb_stb_o, 1'b1);
        end
        tick(); #3 chk("t4 stb dropped", wb_stb_o, 1'b0);
        // write flushed in its second busy cycle, then a normal write
        ce = 1'b1; we = 1'b1; addr = 32'h500; wdat = 32'h12345678; sel = 4'h3;
        tick(); ce = 1'b0;
        #3 chk("t5 wdata", wb_data_o, 32'h12345678); chk("t5 we", wb_we_o, 1'b1); chk("t5 sel", wb_sel_o, 4'h3);
        tick(); flush = 1'b1; #3 chk("t5 flush err", bus_err_o, 1'b0);
        tick(); flush = 1'b0; #3 chk("t5 cleared stb", wb_stb_o, 1'b0); chk("t5 cleared addr", wb_addr_o, 32'h0);
        ce = 1'b1; addr = 32'h600; wdat = 32'hA5A5A5A5;
        tick(); ce = 1'b0; ack = 1'b1; rdat = 32'hFFFFFFFF;
        #3 chk("t5 write ack data", cpu_data_o, 32'h0); chk("t5 write ack stallreq", stallreq, 1'b0);
        tick(); ack = 1'b0; rdat = '0; we = 1'b0;
        // error under stall shows the error flag while waiting
        ce = 1'b1; addr = 32'h700;
        tick(); ce = 1'b0; err = 1'b1; stall = 6'b000001; #3 chk("t6 err", bus_err_o, 1'b1);
        tick(); err = 1'b0; stall = '0; #3 chk("t6 wait err", bus_err_o, 1'b1); chk("t6 wait data", cpu_data_o, 32'h0);
        tick();
        // a request together with flush is not accepted
        ce = 1'b1; flush = 1'b1; #3 chk("t7 flush stallreq", stallreq, 1'b0);
        tick(); ce = 1'b0; flush = 1'b0; #3 chk("t7 not accepted", wb_stb_o, 1'b0);
        // reset mid-access drops the strobe without a clock edge
        ce = 1'b1; addr = 32'h800;
        tick(); ce = 1'b0;
        #2 rst = 1'b1;
        #1 chk("t8 rst stb", wb_stb_o, 1'b0); chk("t8 rst cyc", wb_cyc_o, 1'b0); chk("t8 rst stallreq", stallreq, 1'b0);
        tick(); rst = 1'b0; ce = 1'b1; addr = 32'h900;
        tick(); ce = 1'b0; ack = 1'b1; rdat = 32'hCAFEF00D;
        #3 chk("t8 read data", cpu_data_o, 32'hCAFEF00D); chk("t8 addr", wb_addr_o, 32'h900);
        tick(); ack = 1'b0; rdat = '0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
